nor_rr_scheduler: RTL and testbench

NOR_RR_SCHEDULER -- requirements
Module: nor_rr_scheduler

---
 rtl/nor_rr_scheduler.sv | 114 +++++++++++
 tb/tb_nor_rr_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nor_rr_scheduler.sv
// ============================================================================
// nor_rr_scheduler : four lanes share one registered 2-input NOR unit,
//                    granted round-robin, one operation every four cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nor_rr_scheduler (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  input  logic [3:0] op_a_i,
  input  logic [3:0] op_b_i,
  output logic [3:0] grant_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] done_lane_o,
  output logic       result_o,
  output logic [3:0] res_vec_o,
  output logic [3:0] valid_vec_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [1:0] ptr_q;
  logic       opa_q, opb_q;
  logic       nor_q;
  logic [3:0] res_q;
  logic [3:0] valid_q;

  logic [1:0] sel_lane;
  logic [1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    sel_lane = ptr_q;
    cand     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req_i[cand]) begin
        sel_lane = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          lane_d  = sel_lane;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_EVAL;
      S_EVAL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      lane_q  <= 2'd0;
      ptr_q   <= 2'd0;
      opa_q   <= 1'b0;
      opb_q   <= 1'b0;
      nor_q   <= 1'b0;
      res_q   <= 4'd0;
      valid_q <= 4'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      case (state_q)
        S_LOAD: begin
          opa_q           <= op_a_i[lane_q];
          opb_q           <= op_b_i[lane_q];
          valid_q[lane_q] <= 1'b0;
        end
        S_EVAL: begin
          nor_q <= ~(opa_q | opb_q);
        end
        S_DONE: begin
          res_q[lane_q]   <= nor_q;
          valid_q[lane_q] <= 1'b1;
          ptr_q           <= lane_q + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Every output is a decode of registered state only.
  assign busy_o      = (state_q != S_IDLE);
  assign grant_o     = busy_o ? (4'b0001 << lane_q) : 4'b0000;
  assign done_o      = (state_q == S_DONE);
  assign done_lane_o = done_o ? lane_q : 2'd0;
  assign result_o    = done_o & nor_q;
  assign res_vec_o   = res_q;
  assign valid_vec_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_nor_rr_scheduler.sv
// ============================================================================
// tb_nor_rr_scheduler : vector table, corner sequences and randomized run
//                       against an operation-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nor_rr_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req, op_a, op_b;
  logic [3:0] grant;
  logic       busy, done;
  logic [1:0] done_lane;
  logic       result;
  logic [3:0] res_vec, valid_vec;

  int checks   = 0;
  int failures = 0;

  nor_rr_scheduler dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .req_i       (req),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .grant_o     (grant),
    .busy_o      (busy),
    .done_o      (done),
    .done_lane_o (done_lane),
    .result_o    (result),
    .res_vec_o   (res_vec),
    .valid_vec_o (valid_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: tracks the operation in flight as a cycle count into it.
  int m_phase, m_lane, m_ptr;
  bit m_a, m_b, m_r;
  bit m_res [4];
  bit m_val [4];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_lane = 0; m_ptr = 0; m_a = 0; m_b = 0; m_r = 0;
      for (int i = 0; i < 4; i++) begin m_res[i] = 0; m_val[i] = 0; end
    end else begin
      case (m_phase)
        0: if (req != 4'd0) begin
             for (int k = 3; k >= 0; k--)
               if (req[(m_ptr + k) % 4]) m_lane = (m_ptr + k) % 4;
             m_phase = 1;
           end
        1: begin m_a = op_a[m_lane]; m_b = op_b[m_lane]; m_val[m_lane] = 0; m_phase = 2; end
        2: begin m_r = !(m_a || m_b); m_phase = 3; end
        default: begin
             m_res[m_lane] = m_r; m_val[m_lane] = 1;
             m_ptr = (m_lane + 1) % 4; m_phase = 0;
           end
      endcase
    end
  end

  function automatic logic [16:0] model_vec();
    logic [3:0] g, rv, vv;
    logic       d;
    g = (m_phase != 0) ? 4'(1 << m_lane) : 4'd0;
    d = (m_phase == 3);
    for (int i = 0; i < 4; i++) begin rv[i] = m_res[i]; vv[i] = m_val[i]; end
    return {g, m_phase != 0, d, d ? 2'(m_lane) : 2'd0, d & m_r, rv, vv};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {grant, busy, done, done_lane, result, res_vec, valid_vec};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req, a, b;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic r, input logic [3:0] rq, a, b,
                      input logic [3:0] g, input logic bz, dn, input logic [1:0] dl,
                      input logic rs, input logic [3:0] rv, vv);
    vec_t v;
    v.rst = r; v.req = rq; v.a = a; v.b = b;
    v.exp = {g, bz, dn, dl, rs, rv, vv};
    tbl.push_back(v);
  endtask

  initial begin
    int   cnt;
    logic bad;
    logic [3:0] fair_exp [4];

    rst = 1'b1; req = 4'd0; op_a = 4'd0; op_b = 4'd0;

    // Reset with req=1111, then single lane 0.
    addv(1, 4'hF, 0, 0,   4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    addv(1, 4'hF, 0, 0,   4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    addv(0, 4'h1, 0, 0,   4'h1, 1, 0, 0, 0, 4'h0, 4'h0);
    addv(0, 4'h1, 0, 0,   4'h1, 1, 0, 0, 0, 4'h0, 4'h0);
    addv(0, 4'h0, 0, 0,   4'h1, 1, 1, 0, 1, 4'h0, 4'h0);
    addv(0, 4'h0, 0, 0,   4'h0, 0, 0, 0, 0, 4'h1, 4'h1);
    // All lanes, operands (0,0),(0,1),(1,0),(1,1).
    addv(1, 4'h0, 0, 0,   4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h1, 1, 0, 0, 0, 4'h0, 4'h0);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h1, 1, 0, 0, 0, 4'h0, 4'h0);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h1, 1, 1, 0, 1, 4'h0, 4'h0);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h0, 0, 0, 0, 0, 4'h1, 4'h1);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h2, 1, 0, 0, 0, 4'h1, 4'h1);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h2, 1, 0, 0, 0, 4'h1, 4'h1);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h2, 1, 1, 1, 0, 4'h1, 4'h1);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h0, 0, 0, 0, 0, 4'h1, 4'h3);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h4, 1, 0, 0, 0, 4'h1, 4'h3);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h4, 1, 0, 0, 0, 4'h1, 4'h3);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h4, 1, 1, 2, 0, 4'h1, 4'h3);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h0, 0, 0, 0, 0, 4'h1, 4'h7);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h8, 1, 0, 0, 0, 4'h1, 4'h7);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h8, 1, 0, 0, 0, 4'h1, 4'h7);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h8, 1, 1, 3, 0, 4'h1, 4'h7);
    addv(0, 4'hF, 4'hC, 4'hA, 4'h0, 0, 0, 0, 0, 4'h1, 4'hF);
    // Wrap back to lane 0; its valid bit clears on the LOAD edge.
    addv(0, 4'hF, 4'hC, 4'hA, 4'h1, 1, 0, 0, 0, 4'h1, 4'hF);
    addv(0, 4'h0, 4'hC, 4'hA, 4'h1, 1, 0, 0, 0, 4'h1, 4'hE);
    addv(1, 4'h0, 0, 0,   4'h0, 0, 0, 0, 0, 4'h0, 4'h0);

    #2;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; op_a = tbl[i].a; op_b = tbl[i].b;
      tick();
      check($sformatf("vec[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Fairness with req=0101 held.
    fair_exp[0] = 4'h1; fair_exp[1] = 4'h4; fair_exp[2] = 4'h1; fair_exp[3] = 4'h4;
    rst = 1; req = 0; tick(); rst = 0; req = 4'h5; bad = 0;
    for (int op = 0; op < 4; op++) begin
      cnt = 0;
      while (grant == 4'd0 && cnt < 8) begin tick(); cnt++; bad |= grant[1] | grant[3]; end
      check($sformatf("fair_grant[%0d]", op), 17'(grant), 17'(fair_exp[op]));
      cnt = 0;
      while (grant != 4'd0 && cnt < 8) begin tick(); cnt++; bad |= grant[1] | grant[3]; end
    end
    check("fair_lanes13_never", 17'(bad), 17'd0);

    // Reset during EVAL of lane 2.
    rst = 1; req = 0; tick(); rst = 0;
    req = 4'h4; tick();
    check("mid_load_grant", 17'(grant), 17'h4);
    req = 4'h0; tick();
    rst = 1; tick(); rst = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin tick(); bad |= done; end
    check("mid_no_done", 17'(bad), 17'd0);
    check("mid_vecs", 17'({res_vec, valid_vec}), 17'd0);
    req = 4'h8; tick();
    check("mid_lane3_grant", 17'(grant), 17'h8);
    req = 4'h0; tick(); tick();
    check("mid_lane3_done", 17'({done, done_lane}), 17'({1'b1, 2'd3}));

    // Operand flip during EVAL must not change the captured result.
    rst = 1; tick(); rst = 0;
    req = 4'h2; op_a = 4'h0; op_b = 4'h0; tick();
    req = 4'h0; tick();
    op_a = 4'hF; tick();
    check("hold_result", 17'({done, done_lane, result}), 17'({1'b1, 2'd1, 1'b1}));
    tick();
    check("hold_res_vec", 17'({res_vec, valid_vec}), 17'({4'h2, 4'h2}));

    // Randomized run against the model.
    rst = 1; tick();
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 99) < 2);
      req  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      op_a = 4'($urandom);
      op_b = 4'($urandom);
      tick();
      check($sformatf("rand[%0d]", c), dut_vec(), model_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
